// File: rtl/alu_muldiv_if.sv
// Request/response bundle between the pipeline and the EX-stage ALU with multiply/divide.
interface alu_muldiv_if #(
   parameter int unsigned WORD_WIDTH = 32
);
   logic                  in_valid;
   logic                  in_ready;
   logic [3:0]            opcode;
   logic [WORD_WIDTH-1:0] a_input;
   logic [WORD_WIDTH-1:0] b_input;
   logic                  out_valid;
   logic [WORD_WIDTH-1:0] resultado;
   logic                  zero;
   logic                  overflow;
   logic                  div_by_zero;
   logic                  busy;

   modport master (
      output in_valid, opcode, a_input, b_input,
      input  in_ready, out_valid, resultado, zero, overflow, div_by_zero, busy
   );

   modport slave (
      input  in_valid, opcode, a_input, b_input,
      output in_ready, out_valid, resultado, zero, overflow, div_by_zero, busy
   );
endinterface

// File: rtl/alu_muldiv.sv
// Registered ALU with iterative shift-add multiply and restoring divide into HI/LO.
module alu_muldiv #(
   parameter int unsigned WORD_WIDTH = 32,
   parameter int unsigned CNT_W      = 6
) (
   input logic         clk,
   input logic         reset,
   alu_muldiv_if.slave bus
);
   localparam int unsigned W = WORD_WIDTH;

   localparam logic [3:0] OpAnd   = 4'b0000;
   localparam logic [3:0] OpOr    = 4'b0001;
   localparam logic [3:0] OpAdd   = 4'b0010;
   localparam logic [3:0] OpXor   = 4'b0011;
   localparam logic [3:0] OpSub   = 4'b0110;
   localparam logic [3:0] OpSlt   = 4'b0111;
   localparam logic [3:0] OpMult  = 4'b1000;
   localparam logic [3:0] OpMultu = 4'b1001;
   localparam logic [3:0] OpDiv   = 4'b1010;
   localparam logic [3:0] OpDivu  = 4'b1011;
   localparam logic [3:0] OpNor   = 4'b1100;
   localparam logic [3:0] OpMfhi  = 4'b1101;
   localparam logic [3:0] OpMflo  = 4'b1110;

   typedef enum logic [1:0] {StIdle, StMul, StDiv, StDone} state_e;

   state_e           state_q, state_d;
   logic [W-1:0]     acc_q, acc_d;     // product upper half / partial remainder
   logic [W-1:0]     work_q, work_d;   // multiplier bits / dividend-to-quotient
   logic [W-1:0]     opnd_q, opnd_d;   // multiplicand / divisor magnitude
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             neg_q, neg_d;     // product or quotient must be negated
   logic             rem_neg_q, rem_neg_d;
   logic [W-1:0]     hi_q, hi_d, lo_q, lo_d, res_q, res_d;
   logic             zero_q, zero_d, ovf_q, ovf_d, dbz_q, dbz_d, out_valid_q, out_valid_d;

   logic             in_ready, accept, last, sgn, single, op_ovf, op_dbz;
   logic [W-1:0]     a, b, a_mag, b_mag, op_res;
   logic [W:0]       sum, shifted, diff;
   logic [W-1:0]     mul_acc, mul_lo, div_rem, div_quo, quo_fix, rem_fix;
   logic [2*W-1:0]   prod, prod_fix;

   assign a        = bus.a_input;
   assign b        = bus.b_input;
   assign in_ready = (state_q == StIdle) || (state_q == StDone);
   assign accept   = bus.in_valid && in_ready;
   assign last     = (cnt_q == CNT_W'(W - 1));
   assign sgn      = (bus.opcode == OpMult) || (bus.opcode == OpDiv);
   assign a_mag    = (sgn && a[W-1]) ? -a : a;
   assign b_mag    = (sgn && b[W-1]) ? -b : b;

   // One shift-add multiply step: conditionally add, then shift the 2W pair right.
   assign sum      = {1'b0, acc_q} + (work_q[0] ? {1'b0, opnd_q} : '0);
   assign mul_acc  = sum[W:1];
   assign mul_lo   = {sum[0], work_q[W-1:1]};
   assign prod     = {mul_acc, mul_lo};
   assign prod_fix = neg_q ? -prod : prod;

   // One restoring divide step: shift in the next dividend bit, keep the difference if non-negative.
   assign shifted  = {acc_q, work_q[W-1]};
   assign diff     = shifted - {1'b0, opnd_q};
   assign div_rem  = diff[W] ? shifted[W-1:0] : diff[W-1:0];
   assign div_quo  = {work_q[W-2:0], ~diff[W]};
   assign quo_fix  = neg_q ? -div_quo : div_quo;
   assign rem_fix  = rem_neg_q ? -div_rem : div_rem;

   // Next-state, iteration datapath and issue decode.
   always_comb begin
      state_d     = state_q;
      acc_d       = acc_q;
      work_d      = work_q;
      opnd_d      = opnd_q;
      cnt_d       = cnt_q;
      neg_d       = neg_q;
      rem_neg_d   = rem_neg_q;
      hi_d        = hi_q;
      lo_d        = lo_q;
      res_d       = res_q;
      zero_d      = zero_q;
      ovf_d       = ovf_q;
      dbz_d       = dbz_q;
      out_valid_d = 1'b0;
      op_res      = '0;
      op_ovf      = 1'b0;
      op_dbz      = 1'b0;
      single      = 1'b0;

      unique case (state_q)
         StMul: begin
            acc_d  = mul_acc;
            work_d = mul_lo;
            cnt_d  = cnt_q + CNT_W'(1);
            if (last) begin
               hi_d        = prod_fix[2*W-1:W];
               lo_d        = prod_fix[W-1:0];
               res_d       = prod_fix[W-1:0];
               zero_d      = (prod_fix[W-1:0] == '0);
               ovf_d       = 1'b0;
               dbz_d       = 1'b0;
               out_valid_d = 1'b1;
               state_d     = StDone;
            end
         end
         StDiv: begin
            acc_d  = div_rem;
            work_d = div_quo;
            cnt_d  = cnt_q + CNT_W'(1);
            if (last) begin
               hi_d        = rem_fix;
               lo_d        = quo_fix;
               res_d       = quo_fix;
               zero_d      = (quo_fix == '0);
               ovf_d       = 1'b0;
               dbz_d       = 1'b0;
               out_valid_d = 1'b1;
               state_d     = StDone;
            end
         end
         StDone:  state_d = StIdle;
         default: ;
      endcase

      // A request accepted in DONE is handled exactly as in IDLE.
      if (accept) begin
         single = 1'b1;
         case (bus.opcode)
            OpAdd: begin
               op_res = a + b;
               op_ovf = (a[W-1] == b[W-1]) && (op_res[W-1] != a[W-1]);
            end
            OpSub: begin
               op_res = a - b;
               op_ovf = (a[W-1] != b[W-1]) && (op_res[W-1] != a[W-1]);
            end
            OpAnd:  op_res = a & b;
            OpOr:   op_res = a | b;
            OpNor:  op_res = ~(a | b);
            OpXor:  op_res = a ^ b;
            OpSlt:  op_res = {{(W-1){1'b0}}, ($signed(a) < $signed(b))};
            OpMfhi: op_res = hi_q;
            OpMflo: op_res = lo_q;
            OpMult, OpMultu: begin
               single    = 1'b0;
               acc_d     = '0;
               work_d    = a_mag;
               opnd_d    = b_mag;
               neg_d     = sgn && (a[W-1] ^ b[W-1]);
               rem_neg_d = 1'b0;
               cnt_d     = '0;
               state_d   = StMul;
            end
            OpDiv, OpDivu: begin
               if (b == '0) begin
                  op_res = '1;
                  op_dbz = 1'b1;
                  hi_d   = a;
                  lo_d   = '1;
               end else begin
                  single    = 1'b0;
                  acc_d     = '0;
                  work_d    = a_mag;
                  opnd_d    = b_mag;
                  neg_d     = sgn && (a[W-1] ^ b[W-1]);
                  rem_neg_d = sgn && a[W-1];
                  cnt_d     = '0;
                  state_d   = StDiv;
               end
            end
            default: op_res = a;
         endcase
         if (single) begin
            out_valid_d = 1'b1;
            res_d       = op_res;
            zero_d      = (op_res == '0);
            ovf_d       = op_ovf;
            dbz_d       = op_dbz;
         end
      end
   end

   // State and datapath registers; reset discards any partial operation.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q     <= StIdle;
         acc_q       <= '0;
         work_q      <= '0;
         opnd_q      <= '0;
         cnt_q       <= '0;
         neg_q       <= 1'b0;
         rem_neg_q   <= 1'b0;
         hi_q        <= '0;
         lo_q        <= '0;
         res_q       <= '0;
         zero_q      <= 1'b0;
         ovf_q       <= 1'b0;
         dbz_q       <= 1'b0;
         out_valid_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         acc_q       <= acc_d;
         work_q      <= work_d;
         opnd_q      <= opnd_d;
         cnt_q       <= cnt_d;
         neg_q       <= neg_d;
         rem_neg_q   <= rem_neg_d;
         hi_q        <= hi_d;
         lo_q        <= lo_d;
         res_q       <= res_d;
         zero_q      <= zero_d;
         ovf_q       <= ovf_d;
         dbz_q       <= dbz_d;
         out_valid_q <= out_valid_d;
      end
   end

   assign bus.in_ready    = in_ready;
   assign bus.busy        = ~in_ready;
   assign bus.out_valid   = out_valid_q;
   assign bus.resultado   = res_q;
   assign bus.zero        = zero_q;
   assign bus.overflow    = ovf_q;
   assign bus.div_by_zero = dbz_q;
endmodule

// File: tb/tb_alu_muldiv.sv
// Scoreboard bench for alu_muldiv: driver pushes model results, monitor pops on out_valid.
module tb_alu_muldiv;
   localparam longint SMax = 64'sd2147483647;
   localparam longint SMin = -64'sd2147483648;

   typedef struct packed {
      logic [31:0] res;
      logic        zero;
      logic        ovf;
      logic        dbz;
   } exp_t;

   logic clk = 1'b0;
   logic reset;
   int   vectors = 0;
   int   miscompares = 0;
   exp_t exp_q[$];
   logic [31:0] hi_m, lo_m;

   alu_muldiv_if #(.WORD_WIDTH(32)) bus ();

   alu_muldiv #(.WORD_WIDTH(32), .CNT_W(6)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   // Reference model: plain 64-bit arithmetic, HI/LO tracked in program order.
   function automatic exp_t model(input logic [3:0] op, input logic [31:0] a,
                                  input logic [31:0] b);
      exp_t        e;
      longint      sa, sb, s;
      logic [63:0] p;
      sa    = longint'($signed(a));
      sb    = longint'($signed(b));
      e.ovf = 1'b0;
      e.dbz = 1'b0;
      case (op)
         4'b0010: begin s = sa + sb; e.res = a + b; e.ovf = (s > SMax) || (s < SMin); end
         4'b0110: begin s = sa - sb; e.res = a - b; e.ovf = (s > SMax) || (s < SMin); end
         4'b0000: e.res = a & b;
         4'b0001: e.res = a | b;
         4'b1100: e.res = ~(a | b);
         4'b0011: e.res = a ^ b;
         4'b0111: e.res = (sa < sb) ? 32'd1 : 32'd0;
         4'b1000: begin p = 64'(sa * sb); hi_m = p[63:32]; lo_m = p[31:0]; e.res = lo_m; end
         4'b1001: begin p = 64'(a) * 64'(b); hi_m = p[63:32]; lo_m = p[31:0]; e.res = lo_m; end
         4'b1010, 4'b1011: begin
            if (b == 32'd0) begin
               hi_m = a; lo_m = 32'hFFFF_FFFF; e.res = lo_m; e.dbz = 1'b1;
            end else if (op == 4'b1010) begin
               lo_m = 32'(sa / sb); hi_m = 32'(sa % sb); e.res = lo_m;
            end else begin
               lo_m = a / b; hi_m = a % b; e.res = lo_m;
            end
         end
         4'b1101: e.res = hi_m;
         4'b1110: e.res = lo_m;
         default: e.res = a;
      endcase
      e.zero = (e.res == 32'd0);
      return e;
   endfunction

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
      vectors++;
      if (got !== want) begin
         miscompares++;
         $display("FAIL %s: got %h, expected %h", name, got, want);
      end
   endtask

   // Hold the request (with scrambled operands while busy) until accepted, then log its result.
   task automatic issue(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
      int guard = 0;
      @(negedge clk);
      bus.in_valid = 1'b1;
      bus.opcode   = op;
      while (!bus.in_ready && guard < 200) begin
         bus.a_input = $urandom;
         bus.b_input = $urandom;
         @(negedge clk);
         guard++;
      end
      if (guard >= 200) begin
         vectors++;
         miscompares++;
         $display("FAIL issue_timeout: in_ready stayed 0, expected 1 within 200 cycles");
         bus.in_valid = 1'b0;
      end else begin
         bus.a_input = a;
         bus.b_input = b;
         exp_q.push_back(model(op, a, b));
      end
   endtask

   task automatic idle();
      @(negedge clk);
      bus.in_valid = 1'b0;
   endtask

   function automatic logic [31:0] pick();
      case ($urandom_range(0, 7))
         0:       return 32'd0;
         1:       return 32'h8000_0000;
         2:       return 32'hFFFF_FFFF;
         3:       return 32'd1;
         default: return $urandom;
      endcase
   endfunction

   // Monitor: every out_valid pulse must match the oldest outstanding expectation.
   always @(negedge clk) begin
      exp_t e;
      if (!reset && bus.out_valid) begin
         vectors++;
         if (exp_q.size() == 0) begin
            miscompares++;
            $display("FAIL unexpected_out: got resultado=%h, expected no out_valid", bus.resultado);
         end else begin
            e = exp_q.pop_front();
            if ({bus.resultado, bus.zero, bus.overflow, bus.div_by_zero} !== e) begin
               miscompares++;
               $display("FAIL result: got res=%h z=%b ov=%b dbz=%b, expected res=%h z=%b ov=%b dbz=%b",
                        bus.resultado, bus.zero, bus.overflow, bus.div_by_zero,
                        e.res, e.zero, e.ovf, e.dbz);
            end
         end
      end
   end

   initial begin
      int cnt;
      reset        = 1'b1;
      bus.in_valid = 1'b0;
      bus.opcode   = 4'd0;
      bus.a_input  = '0;
      bus.b_input  = '0;
      hi_m         = '0;
      lo_m         = '0;
      repeat (2) @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
      chk("reset_out_valid", {31'd0, bus.out_valid}, 32'd0);
      chk("reset_resultado", bus.resultado, 32'd0);
      chk("reset_flags", {29'd0, bus.zero, bus.overflow, bus.div_by_zero}, 32'd0);
      chk("reset_ready_busy", {30'd0, bus.in_ready, bus.busy}, 32'd2);

      // Overflowing add, then back-to-back single-cycle ops.
      issue(4'b0010, 32'h7FFF_FFFF, 32'd1);
      issue(4'b0110, 32'd5, 32'd5);
      issue(4'b1100, 32'd0, 32'd0);
      issue(4'b0111, 32'hFFFF_FFFF, 32'd1);
      idle();

      // Signed multiply: busy for exactly 32 cycles, result in the following cycle.
      issue(4'b1000, 32'hFFFF_FFFD, 32'd7);
      idle();
      cnt = 0;
      while (bus.busy && cnt < 100) begin
         cnt++;
         @(negedge clk);
      end
      chk("mult_busy_cycles", 32'(cnt), 32'd32);
      chk("mult_out_valid", {31'd0, bus.out_valid}, 32'd1);
      issue(4'b1101, 32'd0, 32'd0);
      issue(4'b1110, 32'd0, 32'd0);

      // Signed divide, divide by zero, most-negative / -1.
      issue(4'b1010, 32'hFFFF_FFF9, 32'd2);
      issue(4'b1101, 32'd0, 32'd0);
      issue(4'b1110, 32'd0, 32'd0);
      issue(4'b1011, 32'd7, 32'd0);
      issue(4'b1101, 32'd0, 32'd0);
      issue(4'b1010, 32'h8000_0000, 32'hFFFF_FFFF);
      issue(4'b1101, 32'd0, 32'd0);

      // Unsigned max multiply with the next request held through busy and taken in DONE.
      issue(4'b1001, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
      issue(4'b0010, 32'd3, 32'd4);
      chk("accept_in_done", {31'd0, bus.out_valid}, 32'd1);
      issue(4'b1101, 32'd0, 32'd0);
      issue(4'b1110, 32'd0, 32'd0);
      idle();

      // Reset in the middle of a divide.
      issue(4'b1010, 32'd1000, 32'd3);
      idle();
      repeat (9) @(negedge clk);
      #2 reset = 1'b1;
      #1;
      chk("midreset_out_valid", {31'd0, bus.out_valid}, 32'd0);
      chk("midreset_resultado", bus.resultado, 32'd0);
      chk("midreset_ready_busy", {30'd0, bus.in_ready, bus.busy}, 32'd2);
      chk("midreset_flags", {29'd0, bus.zero, bus.overflow, bus.div_by_zero}, 32'd0);
      exp_q.delete();
      hi_m = '0;
      lo_m = '0;
      @(negedge clk);
      reset = 1'b0;
      issue(4'b1101, 32'd0, 32'd0);
      issue(4'b1110, 32'd0, 32'd0);
      issue(4'b0010, 32'd10, 32'd20);
      idle();

      // Randomised mix with occasional bubbles.
      for (int i = 0; i < 400; i++) begin
         issue(4'($urandom_range(0, 15)), pick(), pick());
         if ($urandom_range(0, 3) == 0) idle();
      end
      idle();

      cnt = 0;
      while (exp_q.size() > 0 && cnt < 100) begin
         cnt++;
         @(negedge clk);
      end
      if (exp_q.size() > 0) begin
         vectors++;
         miscompares++;
         $display("FAIL drain: got %0d results outstanding, expected 0", exp_q.size());
      end
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule

// File: doc/alu_muldiv.md
Name: alu_muldiv

Overview:
- Registered, parametrised successor to the pipeline's combinational EX-stage ALU.
- Keeps the existing 4-bit opcode set and adds SLT, XOR, signed-overflow detection, and iterative multiply/divide into HI/LO registers, with MFHI/MFLO reads.
- Uses a valid/ready handshake so the hazard unit can stall the pipeline while a multi-cycle operation runs.

Parameters:
- WORD_WIDTH, 32, operand/result width in bits; must be ≥4 and even.
- CNT_W, 6, iteration-counter width; must satisfy 2^CNT_W > WORD_WIDTH.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-high reset.
- in_valid  input  1  operation request.
- in_ready  output  1  block can accept; a transfer occurs when in_valid && in_ready.
- opcode  input  4  operation select.
- a_input  input  WORD_WIDTH  operand A (signed or unsigned per opcode).
- b_input  input  WORD_WIDTH  operand B.
- out_valid  output  1  one-cycle pulse; result fields are valid.
- resultado  output  WORD_WIDTH  result.
- zero  output  1  resultado == 0; qualified by out_valid.
- overflow  output  1  signed overflow for ADD/SUB; 0 for all other ops.
- div_by_zero  output  1  DIV/DIVU issued with b_input == 0.
- busy  output  1  multi-cycle operation in progress (equals ~in_ready).

Behaviour:
- Opcodes:
  - 0010 ADD, 0110 SUB, 0000 AND, 0001 OR, 1100 NOR, 0011 XOR.
  - 0111 SLT: signed compare; result is 1 or 0.
  - 1000 MULT, 1001 MULTU, 1010 DIV, 1011 DIVU.
  - 1101 MFHI, 1110 MFLO.
  - Any other code: pass a_input.
- Reset: state=IDLE; in_ready=1; out_valid=0; resultado=0; zero=0; overflow=0; div_by_zero=0; busy=0; HI=0; LO=0; counter=0. Reset is honoured in any state, including mid-operation; a partial product or quotient is discarded and HI/LO are cleared.
- States: IDLE, MUL, DIV, DONE.
- IDLE:
  - Single-cycle op accepted: compute, register the result, and assert out_valid on the next edge. Latency is 1 cycle; back-to-back acceptance every cycle; stay in IDLE.
  - MULT/MULTU accepted: latch |A|, |B| (MULT) or raw operands (MULTU), record the result sign; counter=0; go to MUL; in_ready=0.
  - DIV/DIVU accepted with b≠0: same operand latching; go to DIV.
  - DIV/DIVU accepted with b==0: single-cycle. HI=a_input, LO=all ones, div_by_zero=1, resultado=all ones, out_valid next cycle; no state change.
- MUL: one shift-add step per cycle for WORD_WIDTH cycles. After the last step, apply sign correction (two's complement of the 2W product if signs differ), write HI=upper W bits and LO=lower W bits, go to DONE.
- DIV: one restoring shift-subtract step per cycle for WORD_WIDTH cycles. Apply sign correction: quotient truncates toward zero; remainder takes the dividend's sign. Write LO=quotient, HI=remainder, go to DONE.
  - Signed most-negative / −1: quotient=most-negative, remainder=0, no flag.
- DONE: assert out_valid for one cycle with resultado=LO (new value) and zero computed on it; in_ready=1 in the same cycle. Return to IDLE.
  - A request presented during DONE is accepted, so issue is seamless.
  - MUL/DIV latency: WORD_WIDTH+1 cycles from accept to out_valid.
- in_valid while busy: ignored; the requester must hold it. Operand changes during MUL/DIV have no effect.
- MFHI/MFLO: single-cycle; return the current HI/LO registers.
- Flags:
  - overflow = operand signs equal (ADD) or differ (SUB) and result sign differs from A.
  - div_by_zero and overflow are registered alongside resultado and cleared on the next out_valid.
- Without a transfer, out_valid=0 and resultado holds its last value.

Test Plan:
- Reset, then ADD 0x7FFFFFFF + 1 -> out_valid 1 cycle later; resultado=0x80000000; overflow=1; zero=0.
- Back-to-back SUB 5−5, NOR 0|0, SLT −1<1 on consecutive cycles -> three consecutive out_valid pulses: (0, zero=1), (0xFFFFFFFF), (1).
- MULT −3 × 7, then MFHI, MFLO -> in_ready low for 32 cycles; out_valid at cycle 33 with resultado=0xFFFFFFEB; HI=0xFFFFFFFF.
- DIV −7 / 2, then DIVU 7 / 0 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF; then 1-cycle result 0xFFFFFFFF, div_by_zero=1, HI=7.
- MULTU 0xFFFFFFFF × 0xFFFFFFFF with in_valid held high and operands changed during busy -> HI=0xFFFFFFFE, LO=1; the second request is accepted in the DONE cycle.
- Assert reset at iteration 10 of a DIV -> all outputs at reset values immediately; HI=LO=0; next ADD completes normally in 1 cycle.
